// File: rtl/vmicro16_intc_apb_pkg.sv
// Shared configuration for the vmicro16 interrupt controller: source count,
// APB slot, register offsets and FSM state encoding.
package vmicro16_intc_apb_pkg;

  localparam int unsigned DEF_NUM_INT     = 8;
  localparam int unsigned APB_PSELX_INTC0 = 5;

  localparam logic [1:0] INTC_ADDR_STATUS = 2'd0;
  localparam logic [1:0] INTC_ADDR_MASK   = 2'd1;
  localparam logic [1:0] INTC_ADDR_CLEAR  = 2'd2;
  localparam logic [1:0] INTC_ADDR_VECTOR = 2'd3;

  typedef enum logic [1:0] {
    INTC_S_IDLE   = 2'd0,
    INTC_S_ASSERT = 2'd1,
    INTC_S_ACK    = 2'd2
  } intc_state_e;

endpackage

// File: rtl/vmicro16_intc_apb_if.sv
// APB slave bus as seen by the interrupt controller.
interface vmicro16_intc_apb_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [1:0]            S_PADDR;
  logic                  S_PWRITE;
  logic                  S_PSELx;
  logic                  S_PENABLE;
  logic [DATA_WIDTH-1:0] S_PWDATA;
  logic [DATA_WIDTH-1:0] S_PRDATA;
  logic                  S_PREADY;

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY
  );

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY
  );
endinterface

// File: rtl/vmicro16_intc_apb_prio_enc.sv
// Lowest-index-first priority encoder used to pick the next interrupt.
module vmicro16_prio_enc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    req,
  output logic                valid,
  output logic [IDX_BITS-1:0] index
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_BITS'(i);
    end
  end

endmodule

// File: rtl/vmicro16_intc_apb.sv
// vmicro16 APB interrupt controller: pending capture, mask, fixed-priority
// dispatch with latched vector/data and acknowledge handshake.
// Optional macro VMICRO16_INTC_EDGE_EN selects rising-edge capture;
// without it sources are level-captured.
module vmicro16_intc_apb
  import vmicro16_intc_apb_pkg::*;
#(
  parameter int unsigned NUM_INT    = DEF_NUM_INT,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_BITS   = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  vmicro16_intc_apb_if.slave            apb,
  input  logic [NUM_INT-1:0]            int_in,
  input  logic [NUM_INT*DATA_WIDTH-1:0] int_data_in,
  output logic                          irq,
  output logic [VEC_BITS-1:0]           irq_vec,
  output logic [DATA_WIDTH-1:0]         irq_data,
  input  logic                          irq_ack
);

  intc_state_e state, state_n;

  logic [NUM_INT-1:0]    pending;
  logic [NUM_INT-1:0]    mask;
  logic [NUM_INT-1:0]    cap_c;
  logic [NUM_INT-1:0]    clr_c;
  logic [NUM_INT-1:0]    ack_clr_c;
  logic                  access_c;
  logic                  wr_c;
  logic                  sel_valid_c;
  logic [VEC_BITS-1:0]   sel_idx_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic                  irq_n;
  logic [VEC_BITS-1:0]   vec_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  unused_pwdata_c;

  assign access_c        = apb.S_PSELx & apb.S_PENABLE;
  assign wr_c            = access_c & apb.S_PWRITE;
  assign apb.S_PREADY    = access_c;
  assign clr_c           = (wr_c && apb.S_PADDR == INTC_ADDR_CLEAR) ? NUM_INT'(apb.S_PWDATA) : '0;
  assign unused_pwdata_c = ^apb.S_PWDATA;

`ifdef VMICRO16_INTC_EDGE_EN
  logic [NUM_INT-1:0] int_q;

  // Previous source levels for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) int_q <= '0;
    else        int_q <= int_in;
  end

  assign cap_c = int_in & ~int_q;
`else
  assign cap_c = int_in;
`endif

  // Pending and mask registers; a fresh capture overrides clear and ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      if (wr_c && apb.S_PADDR == INTC_ADDR_MASK) mask <= NUM_INT'(apb.S_PWDATA);
      pending <= (pending & ~clr_c & ~ack_clr_c) | cap_c;
    end
  end

  vmicro16_prio_enc #(
    .WIDTH    (NUM_INT),
    .IDX_BITS (VEC_BITS)
  ) u_prio_enc (
    .req   (pending & mask),
    .valid (sel_valid_c),
    .index (sel_idx_c)
  );

  // Data slice of the selected source.
  always_comb begin
    sel_data_c = '0;
    for (int i = 0; i < int'(NUM_INT); i++) begin
      if (sel_idx_c == VEC_BITS'(i)) sel_data_c = int_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Dispatch FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INTC_S_IDLE;
      irq      <= 1'b0;
      irq_vec  <= '0;
      irq_data <= '0;
    end else begin
      state    <= state_n;
      irq      <= irq_n;
      irq_vec  <= vec_n;
      irq_data <= data_n;
    end
  end

  // Dispatch FSM next state; vector and data only change on dispatch.
  always_comb begin
    state_n   = state;
    irq_n     = 1'b0;
    vec_n     = irq_vec;
    data_n    = irq_data;
    ack_clr_c = '0;
    unique case (state)
      INTC_S_IDLE: begin
        if (sel_valid_c) begin
          state_n = INTC_S_ASSERT;
          irq_n   = 1'b1;
          vec_n   = sel_idx_c;
          data_n  = sel_data_c;
        end
      end
      INTC_S_ASSERT: begin
        if (irq_ack) state_n = INTC_S_ACK;
        else         irq_n   = 1'b1;
      end
      INTC_S_ACK: begin
        ack_clr_c = NUM_INT'(1) << irq_vec;
        state_n   = INTC_S_IDLE;
      end
      default: state_n = INTC_S_IDLE;
    endcase
  end

  // Combinational read mux, zero outside the access phase.
  always_comb begin
    apb.S_PRDATA = '0;
    if (access_c) begin
      unique case (apb.S_PADDR)
        INTC_ADDR_STATUS: apb.S_PRDATA = DATA_WIDTH'(pending);
        INTC_ADDR_MASK:   apb.S_PRDATA = DATA_WIDTH'(mask);
        INTC_ADDR_CLEAR:  apb.S_PRDATA = '0;
        INTC_ADDR_VECTOR: apb.S_PRDATA = (state == INTC_S_ASSERT) ? DATA_WIDTH'(irq_vec) : '1;
        default:          apb.S_PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_intc_apb.sv
// Directed self-checking bench for vmicro16_intc_apb.
module tb_vmicro16_intc_apb;

  localparam int unsigned NUM_INT = 8;
  localparam int unsigned DW      = 16;
`ifdef VMICRO16_INTC_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic                    clk;
  logic                    reset;
  logic [NUM_INT-1:0]      int_in;
  logic [NUM_INT*DW-1:0]   int_data_in;
  logic                    irq;
  logic [2:0]              irq_vec;
  logic [DW-1:0]           irq_data;
  logic                    irq_ack;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rd;
  logic          rdy;

  vmicro16_intc_apb_if #(.DATA_WIDTH(DW)) apb ();

  vmicro16_intc_apb #(
    .NUM_INT    (NUM_INT),
    .DATA_WIDTH (DW),
    .VEC_BITS   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .apb         (apb),
    .int_in      (int_in),
    .int_data_in (int_data_in),
    .irq         (irq),
    .irq_vec     (irq_vec),
    .irq_data    (irq_data),
    .irq_ack     (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two-cycle APB write; the register updates at the access-phase edge.
  task automatic apb_write(input logic [1:0] a, input logic [DW-1:0] d);
    apb.S_PADDR   = a;
    apb.S_PWDATA  = d;
    apb.S_PWRITE  = 1'b1;
    apb.S_PSELx   = 1'b1;
    apb.S_PENABLE = 1'b0;
    tick();
    apb.S_PENABLE = 1'b1;
    tick();
    apb.S_PSELx   = 1'b0;
    apb.S_PENABLE = 1'b0;
    apb.S_PWRITE  = 1'b0;
  endtask

  // Sample the combinational read path without advancing the clock.
  task automatic apb_peek(input logic [1:0] a, output logic [DW-1:0] d, output logic r);
    apb.S_PADDR   = a;
    apb.S_PWRITE  = 1'b0;
    apb.S_PSELx   = 1'b1;
    apb.S_PENABLE = 1'b1;
    #1;
    d = apb.S_PRDATA;
    r = apb.S_PREADY;
    apb.S_PSELx   = 1'b0;
    apb.S_PENABLE = 1'b0;
    #1;
  endtask

  initial begin
    // Reset with every input high.
    reset         = 1'b0;
    int_in        = '1;
    int_data_in   = '1;
    irq_ack       = 1'b1;
    apb.S_PADDR   = 2'd0;
    apb.S_PWDATA  = '1;
    apb.S_PWRITE  = 1'b1;
    apb.S_PSELx   = 1'b1;
    apb.S_PENABLE = 1'b1;
    repeat (3) tick();
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_vec", 32'(irq_vec), 32'h0);
    chk("rst_data", 32'(irq_data), 32'h0);
    chk("rst_status", 32'(apb.S_PRDATA), 32'h0);
    chk("rst_pready", 32'(apb.S_PREADY), 32'h1);
    apb.S_PADDR = 2'd3;
    #1;
    chk("rst_vector", 32'(apb.S_PRDATA), 32'hFFFF);

    int_in        = '0;
    int_data_in   = '0;
    irq_ack       = 1'b0;
    apb.S_PWRITE  = 1'b0;
    apb.S_PSELx   = 1'b0;
    apb.S_PENABLE = 1'b0;
    apb.S_PWDATA  = '0;
    #1;
    chk("prdata_idle_zero", 32'(apb.S_PRDATA), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Single source dispatch and acknowledge.
    apb_write(2'd1, 16'h0001);
    apb_peek(2'd1, rd, rdy);
    chk("mask_rd", 32'(rd), 32'h01);
    int_in[0] = 1'b1;
    int_data_in[0*DW +: DW] = 16'h1234;
    tick();
    int_in[0] = 1'b0;
    chk("s0_irq_e0", 32'(irq), 32'h0);
    tick();
    chk("s0_irq_e1", 32'(irq), 32'h1);
    chk("s0_vec", 32'(irq_vec), 32'h0);
    chk("s0_data", 32'(irq_data), 32'h1234);
    apb_peek(2'd3, rd, rdy);
    chk("s0_vector_rd", 32'(rd), 32'h0);
    chk("s0_pready", 32'(rdy), 32'h1);
    int_data_in[0*DW +: DW] = 16'hBEEF;
    tick();
    chk("s0_data_hold", 32'(irq_data), 32'h1234);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("s0_irq_after_ack", 32'(irq), 32'h0);
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("s0_status", 32'(rd), 32'h0);
    apb_peek(2'd3, rd, rdy);
    chk("s0_vector_idle", 32'(rd), 32'hFFFF);

    // Two simultaneous sources: lowest index first, then the other.
    apb_write(2'd1, 16'h00FF);
    int_in[5] = 1'b1;
    int_in[2] = 1'b1;
    int_data_in[5*DW +: DW] = 16'h5555;
    int_data_in[2*DW +: DW] = 16'h2222;
    tick();
    int_in[5] = 1'b0;
    int_in[2] = 1'b0;
    tick();
    chk("p_irq_first", 32'(irq), 32'h1);
    chk("p_vec_first", 32'(irq_vec), 32'h2);
    chk("p_data_first", 32'(irq_data), 32'h2222);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("p_irq_ack", 32'(irq), 32'h0);
    tick();
    chk("p_irq_gap", 32'(irq), 32'h0);
    apb_peek(2'd0, rd, rdy);
    chk("p_status_gap", 32'(rd), 32'h20);
    tick();
    chk("p_irq_second", 32'(irq), 32'h1);
    chk("p_vec_second", 32'(irq_vec), 32'h5);
    chk("p_data_second", 32'(irq_data), 32'h5555);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("p_status_end", 32'(rd), 32'h0);

    // Masked source stays pending; unmasking dispatches it.
    apb_write(2'd1, 16'h0000);
    int_in[3] = 1'b1;
    int_data_in[3*DW +: DW] = 16'h3333;
    tick();
    int_in[3] = 1'b0;
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("m_status", 32'(rd), 32'h08);
    chk("m_irq_masked", 32'(irq), 32'h0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("m_ack_ignored", 32'(rd), 32'h08);
    apb_write(2'd0, 16'h0000);
    apb_write(2'd3, 16'h0000);
    apb_peek(2'd0, rd, rdy);
    chk("m_ro_writes", 32'(rd), 32'h08);
    apb_write(2'd1, 16'h0008);
    chk("m_irq_at_write", 32'(irq), 32'h0);
    tick();
    chk("m_irq_unmasked", 32'(irq), 32'h1);
    chk("m_vec", 32'(irq_vec), 32'h3);
    chk("m_data", 32'(irq_data), 32'h3333);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("m_status_clr", 32'(rd), 32'h0);

    // Clear colliding with a fresh capture of the same bit.
    apb_write(2'd1, 16'h0000);
    int_in[3] = 1'b1;
    tick();
    int_in[3] = 1'b0;
    tick();
    apb.S_PADDR   = 2'd2;
    apb.S_PWDATA  = 16'h0008;
    apb.S_PWRITE  = 1'b1;
    apb.S_PSELx   = 1'b1;
    apb.S_PENABLE = 1'b0;
    tick();
    apb.S_PENABLE = 1'b1;
    #1;
    chk("c_clear_reads0", 32'(apb.S_PRDATA), 32'h0);
    int_in[3] = 1'b1;
    tick();
    apb.S_PSELx   = 1'b0;
    apb.S_PENABLE = 1'b0;
    apb.S_PWRITE  = 1'b0;
    int_in[3] = 1'b0;
    apb_peek(2'd0, rd, rdy);
    chk("c_capture_wins", 32'(rd), 32'h08);
    apb_write(2'd2, 16'h0008);
    apb_peek(2'd0, rd, rdy);
    chk("c_w1c", 32'(rd), 32'h0);

    // Source held high across an acknowledge.
    apb_write(2'd1, 16'h0002);
    int_in[1] = 1'b1;
    int_data_in[1*DW +: DW] = 16'h1111;
    tick();
    tick();
    chk("h_irq", 32'(irq), 32'h1);
    chk("h_vec", 32'(irq_vec), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("h_irq_ack", 32'(irq), 32'h0);
    tick();
    chk("h_irq_gap", 32'(irq), 32'h0);
    tick();
    chk("h_irq_redispatch", 32'(irq), EDGE_MODE ? 32'h0 : 32'h1);
    repeat (15) tick();
    chk("h_irq_held", 32'(irq), EDGE_MODE ? 32'h0 : 32'h1);
    int_in[1] = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    apb_peek(2'd0, rd, rdy);
    chk("h_status_end", 32'(rd), 32'h0);

    // Asynchronous reset while an interrupt is presented.
    apb_write(2'd1, 16'h0001);
    int_in[0] = 1'b1;
    tick();
    int_in[0] = 1'b0;
    tick();
    chk("r_irq_before", 32'(irq), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("r_irq_async", 32'(irq), 32'h0);
    apb_peek(2'd1, rd, rdy);
    chk("r_mask", 32'(rd), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("r_irq_after", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
